// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong sound path.
//   buzz_state_e : buzzer sequencer states. The encoding is ordered by event
//                  priority (IDLE lowest, SCORE highest), so a plain magnitude
//                  compare decides whether an event may preempt a state.
//   *_DEF        : default tone durations (game ticks) and jingle length.
//   TICK_W/STEP_W: widths of the tick and step counters.
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALL  = 2'd1,
        ST_PAD   = 2'd2,
        ST_SCORE = 2'd3
    } buzz_state_e;

    localparam int PAD_TICKS_DEF        = 12;
    localparam int WALL_TICKS_DEF       = 6;
    localparam int SCORE_STEP_TICKS_DEF = 16;
    localparam int SCORE_STEPS_DEF      = 6;

    localparam int TICK_W = 5;
    localparam int STEP_W = 3;

    // True when an event mapped to state ev may enter/re-enter over cur.
    function automatic logic may_preempt(input buzz_state_e ev, input buzz_state_e cur);
        return (ev != ST_IDLE) && (ev >= cur);
    endfunction

endpackage

// File: rtl/buzz_timer.sv
// ---------------------------------------------------------------------------
// buzz_timer
// Loadable down-counter advanced by a tick enable.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   tick      : decrement enable (one game tick)
//   load      : load load_val; wins over a tick in the same cycle
//   load_val  : value to load
//   count     : current count
//   term      : count is 1, i.e. the next tick ends the period
// ---------------------------------------------------------------------------
module buzz_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         term
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == W'(1));

endmodule

// File: rtl/buzz_sequencer.sv
// ---------------------------------------------------------------------------
// buzz_sequencer
// Chooses which tone (if any) drives the piezo: a short low tone on a paddle
// hit, a shorter high tone on a wall hit and an alternating low/high jingle
// when a point is scored. Higher-priority events preempt lower ones; lower
// ones are dropped.
//   clk          : pixel clock, all logic on rising edge
//   rst          : synchronous active-high reset
//   game_en      : one-cycle game tick strobe (absent while paused)
//   pad_buzz_en  : free-running low-tone square wave
//   wall_buzz_en : free-running high-tone square wave
//   pad_hit      : paddle strike pulse
//   wall_hit     : wall strike pulse
//   score_hit    : point scored pulse
//   mute         : forces buzzer low while high
//   buzzer       : registered piezo drive
//   busy         : registered, high while not IDLE
// ---------------------------------------------------------------------------
module buzz_sequencer
    import pong_pkg::*;
#(
    parameter int PAD_TICKS        = PAD_TICKS_DEF,
    parameter int WALL_TICKS       = WALL_TICKS_DEF,
    parameter int SCORE_STEP_TICKS = SCORE_STEP_TICKS_DEF,
    parameter int SCORE_STEPS      = SCORE_STEPS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic game_en,
    input  logic pad_buzz_en,
    input  logic wall_buzz_en,
    input  logic pad_hit,
    input  logic wall_hit,
    input  logic score_hit,
    input  logic mute,
    output logic buzzer,
    output logic busy
);

    localparam logic [TICK_W-1:0] PAD_LD   = TICK_W'(PAD_TICKS);
    localparam logic [TICK_W-1:0] WALL_LD  = TICK_W'(WALL_TICKS);
    localparam logic [TICK_W-1:0] SCORE_LD = TICK_W'(SCORE_STEP_TICKS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SCORE_STEPS - 1);

    buzz_state_e        state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               buzzer_q, buzzer_d;
    logic               busy_q, busy_d;

    buzz_state_e        ev_state;
    logic               tmr_load;
    logic [TICK_W-1:0]  tmr_load_val;
    logic [TICK_W-1:0]  tmr_count;
    logic               tmr_term;
    logic               tone;

    buzz_timer #(
        .W (TICK_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (game_en),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (tmr_count),
        .term     (tmr_term)
    );

    // Only the highest-priority event of the cycle is considered.
    always_comb begin
        ev_state = ST_IDLE;
        if (score_hit) begin
            ev_state = ST_SCORE;
        end else if (pad_hit) begin
            ev_state = ST_PAD;
        end else if (wall_hit) begin
            ev_state = ST_WALL;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        if (may_preempt(ev_state, state_q)) begin
            state_d  = ev_state;
            tmr_load = 1'b1;
            case (ev_state)
                ST_SCORE: begin
                    tmr_load_val = SCORE_LD;
                    step_d       = '0;
                end
                ST_PAD:   tmr_load_val = PAD_LD;
                default:  tmr_load_val = WALL_LD;
            endcase
        end else if (game_en && tmr_term) begin
            case (state_q)
                ST_PAD, ST_WALL: state_d = ST_IDLE;
                ST_SCORE: begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                    end else begin
                        step_d       = step_q + 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = SCORE_LD;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Tone is taken from the current state, so buzzer trails state by a cycle.
    always_comb begin
        tone = 1'b0;
        case (state_q)
            ST_PAD:   tone = pad_buzz_en;
            ST_WALL:  tone = wall_buzz_en;
            ST_SCORE: tone = step_q[0] ? wall_buzz_en : pad_buzz_en;
            default:  tone = 1'b0;
        endcase
        buzzer_d = tone & ~mute;
        // busy registers the next state so it is high exactly while state_q != IDLE.
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            buzzer_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            buzzer_q <= buzzer_d;
            busy_q   <= busy_d;
        end
    end

    assign buzzer = buzzer_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_buzz_sequencer.sv
module tb_buzz_sequencer;
    import pong_pkg::*;

    localparam int PT = 12;
    localparam int WT = 6;
    localparam int ST = 16;
    localparam int SS = 6;

    logic clk = 1'b0;
    logic rst, game_en, pad_buzz_en, wall_buzz_en;
    logic pad_hit, wall_hit, score_hit, mute;
    logic buzzer, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: mode ranks 0 idle, 1 wall, 2 pad, 3 score.
    int   m_mode = 0;
    int   m_rem  = 0;
    int   m_step = 0;
    logic m_buzz = 1'b0;
    logic m_busy = 1'b0;

    always #5 clk = ~clk;

    buzz_sequencer #(
        .PAD_TICKS        (PT),
        .WALL_TICKS       (WT),
        .SCORE_STEP_TICKS (ST),
        .SCORE_STEPS      (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_en      (game_en),
        .pad_buzz_en  (pad_buzz_en),
        .wall_buzz_en (wall_buzz_en),
        .pad_hit      (pad_hit),
        .wall_hit     (wall_hit),
        .score_hit    (score_hit),
        .mute         (mute),
        .buzzer       (buzzer),
        .busy         (busy)
    );

    function automatic int dur(input int mode);
        return (mode == 3) ? ST : (mode == 2) ? PT : WT;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic cyc(input logic r, input logic ge, input logic ph, input logic wh,
                       input logic sh, input logic mu, input logic pe, input logic we);
        int ev;
        rst = r; game_en = ge; pad_hit = ph; wall_hit = wh; score_hit = sh;
        mute = mu; pad_buzz_en = pe; wall_buzz_en = we;
        @(posedge clk);
        ev = sh ? 3 : ph ? 2 : wh ? 1 : 0;
        case (m_mode)
            2:       m_buzz = pe & ~mu;
            1:       m_buzz = we & ~mu;
            3:       m_buzz = ((m_step % 2) ? we : pe) & ~mu;
            default: m_buzz = 1'b0;
        endcase
        if (r) begin
            m_mode = 0; m_rem = 0; m_step = 0; m_buzz = 1'b0;
        end else if (ev != 0 && ev >= m_mode) begin
            m_mode = ev;
            m_rem  = dur(ev);
            if (ev == 3) m_step = 0;
        end else if (ge && m_mode != 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                if (m_mode == 3 && m_step < SS - 1) begin
                    m_step = m_step + 1;
                    m_rem  = ST;
                end else begin
                    m_mode = 0;
                    m_step = 0;
                end
            end
        end
        m_busy = (m_mode != 0);
        #1;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer got %b want 0", buzzer); end
        n_cmp++; if (dut.u_timer.count_q !== 5'd0) begin n_fail++; $display("FAIL reset_tick_cnt got %0d want 0", dut.u_timer.count_q); end
        n_cmp++; if (dut.step_q !== 3'd0) begin n_fail++; $display("FAIL reset_step_cnt got %0d want 0", dut.step_q); end
        // Reset must beat an event in the same cycle.
        cyc(1, 1, 1, 1, 1, 0, 1, 1);
        n_cmp++; if (busy !== 1'b0 || dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_vs_event busy %b state %0d want 0/IDLE", busy, dut.state_q); end
    endtask

    task automatic test_pad_tone();
        logic pe;
        do_reset();
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pad_busy_start got %b want 1", busy); end
        for (int k = 1; k <= PT; k++) begin
            for (int g = 0; g < 3; g++) begin
                pe = 1'($urandom);
                cyc(0, 0, 0, 0, 0, 0, pe, ~pe);
                n_cmp++; if (buzzer !== pe) begin n_fail++; $display("FAIL pad_tone tick %0d got %b want %b", k, buzzer, pe); end
            end
            cyc(0, 1, 0, 0, 0, 0, 1'($urandom), 1'($urandom));
            n_cmp++;
            if (busy !== (k < PT)) begin n_fail++; $display("FAIL pad_duration tick %0d busy %b want %b", k, busy, (k < PT)); end
        end
    endtask

    task automatic test_priority();
        int ticks;
        do_reset();
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        n_cmp++; if (dut.state_q !== ST_PAD) begin n_fail++; $display("FAIL prio_same_cycle state %0d want PAD", dut.state_q); end
        ticks = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            cyc(0, 1, 0, (i % 3 == 1), 0, 0, 0, 0);
            ticks++;
        end
        n_cmp++; if (ticks !== PT) begin n_fail++; $display("FAIL prio_wall_ignored ticks %0d want %0d", ticks, PT); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_end busy %b want 0", busy); end
    endtask

    task automatic test_retrigger();
        int ticks;
        do_reset();
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        n_cmp++; if (dut.u_timer.count_q !== 5'(PT)) begin n_fail++; $display("FAIL retrig_reload got %0d want %0d", dut.u_timer.count_q, PT); end
        ticks = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0, 0, 0, 0);
            ticks++;
        end
        n_cmp++; if (ticks !== PT) begin n_fail++; $display("FAIL retrig_ticks got %0d want %0d", ticks, PT); end
    endtask

    task automatic test_score();
        logic want;
        do_reset();
        cyc(0, 0, 0, 0, 1, 0, 1, 0);
        for (int t = 0; t < ST * SS; t++) begin
            // Low tone held high, high tone held low: buzzer shows step parity.
            cyc(0, 0, (t == 48), 0, 0, 0, 1, 0);
            want = ((t / ST) % 2 == 0);
            n_cmp++; if (buzzer !== want) begin n_fail++; $display("FAIL score_tone tick %0d got %b want %b", t, buzzer, want); end
            cyc(0, 1, 0, 0, 0, 0, 1, 0);
            n_cmp++; if (busy !== (t < ST * SS - 1)) begin n_fail++; $display("FAIL score_busy tick %0d got %b want %b", t, busy, (t < ST * SS - 1)); end
        end
    endtask

    task automatic test_mute_pause_reset();
        logic pe;
        do_reset();
        cyc(0, 0, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, 1, 1, 1);
            n_cmp++; if (buzzer !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mute buzzer %b busy %b want 0/1", buzzer, busy); end
        end
        for (int i = 0; i < 1000; i++) begin
            pe = 1'($urandom);
            cyc(0, 0, 0, 0, 0, 0, pe, 0);
            n_cmp++; if (buzzer !== m_buzz) begin n_fail++; $display("FAIL pause_tone cyc %0d got %b want %b", i, buzzer, m_buzz); end
        end
        n_cmp++; if (busy !== 1'b1 || dut.u_timer.count_q !== 5'(PT - 3)) begin n_fail++; $display("FAIL pause_hold busy %b cnt %0d want 1/%0d", busy, dut.u_timer.count_q, PT - 3); end
        do_reset();
        cyc(0, 0, 0, 1, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 1);
        n_cmp++; if (buzzer !== 1'b1) begin n_fail++; $display("FAIL wall_tone got %b want 1", buzzer); end
        cyc(1, 0, 0, 1, 0, 0, 1, 1);
        n_cmp++; if (buzzer !== 1'b0 || busy !== 1'b0 || dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rst_mid_wall buzzer %b busy %b state %0d want 0/0/IDLE", buzzer, busy, dut.state_q); end
    endtask

    task automatic test_random();
        logic r, ge, ph, wh, sh, mu;
        do_reset();
        mu = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            r  = ($urandom_range(0, 799) == 0);
            ge = ($urandom_range(0, 2) == 0);
            sh = ($urandom_range(0, 299) == 0);
            ph = ($urandom_range(0, 39) == 0);
            wh = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) mu = ~mu;
            cyc(r, ge, ph, wh, sh, mu, 1'($urandom), 1'($urandom));
            n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b want %b", i, busy, m_busy); end
            n_cmp++; if (buzzer !== m_buzz) begin n_fail++; $display("FAIL rand_buzzer cyc %0d got %b want %b", i, buzzer, m_buzz); end
        end
    endtask

    initial begin
        rst = 1'b1; game_en = 1'b0; pad_buzz_en = 1'b0; wall_buzz_en = 1'b0;
        pad_hit = 1'b0; wall_hit = 1'b0; score_hit = 1'b0; mute = 1'b0;
        test_reset();
        test_pad_tone();
        test_priority();
        test_retrigger();
        test_score();
        test_mute_pause_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/buzz_sequencer.md
BUZZ_SEQUENCER -- requirements
Module: buzz_sequencer

Interface
REQ-001 Parameters SHALL be: PAD_TICKS, default 12, pad-hit tone duration in game ticks; WALL_TICKS, default 6, wall-hit tone duration in game ticks; SCORE_STEP_TICKS, default 16, duration of each score-jingle step in game ticks; SCORE_STEPS, default 6, number of score-jingle steps.
REQ-002 Port clk, input, 1 bit: the single system clock (25.175 MHz pixel clock); all logic SHALL be clocked on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port game_en, input, 1 bit: one-cycle game tick strobe (about 210 Hz); absent while the game is paused.
REQ-005 Port pad_buzz_en, input, 1 bit: free-running square-wave level for the low tone.
REQ-006 Port wall_buzz_en, input, 1 bit: free-running square-wave level for the high tone.
REQ-007 Port pad_hit, input, 1 bit: one-cycle pulse when the ball strikes a paddle.
REQ-008 Port wall_hit, input, 1 bit: one-cycle pulse when the ball strikes the top or bottom wall.
REQ-009 Port score_hit, input, 1 bit: one-cycle pulse when a point is scored.
REQ-010 Port mute, input, 1 bit: level; forces the buzzer output low while high.
REQ-011 Port buzzer, output, 1 bit: registered drive to the piezo.
REQ-012 Port busy, output, 1 bit: registered; high whenever the state is not IDLE.

Function
REQ-013 The state machine SHALL have the states IDLE, PAD, WALL and SCORE.
REQ-014 Event priority SHALL be score_hit > pad_hit > wall_hit, and only the highest-priority event asserted in a cycle SHALL be taken.
REQ-015 An event of priority equal to or higher than the current state (IDLE lowest) SHALL enter or re-enter its state on the next edge and reload the tick counter (PAD_TICKS, WALL_TICKS or SCORE_STEP_TICKS); a score event SHALL also clear the step counter.
REQ-016 An event of lower priority than the current state SHALL be ignored and SHALL NOT be queued.
REQ-017 The tick counter SHALL decrement by one only in cycles with game_en high; a load in the same cycle SHALL take precedence over the decrement.
REQ-018 In PAD or WALL, a game_en with the tick counter at 1 SHALL move the state to IDLE, so each tone lasts exactly its parameter in game ticks.
REQ-019 In SCORE, a game_en with the tick counter at 1 SHALL advance the step counter and reload SCORE_STEP_TICKS; if the step was SCORE_STEPS-1, the state SHALL instead move to IDLE.
REQ-020 Tone selection SHALL be: PAD uses pad_buzz_en; WALL uses wall_buzz_en; SCORE uses pad_buzz_en on even steps and wall_buzz_en on odd steps; IDLE drives 0.
REQ-021 buzzer SHALL be registered as the selected tone AND NOT mute, so it lags the state register by one cycle.
REQ-022 Without game_en (game paused), the state and counters SHALL hold; buzzer SHALL keep following the (frozen) tone input.
REQ-023 The tick counter SHALL be 5 bits and the step counter 3 bits; parameters SHALL be in the range 1..31 (ticks) and 1..7 (steps), and values outside that range are unsupported.

Reset
REQ-024 While rst is high: state SHALL be IDLE, both counters 0, buzzer 0 and busy 0.
REQ-025 Reset SHALL override all inputs, including an event in the same cycle, and SHALL abort any tone mid-play.

Structure
REQ-026 The state encoding and the default duration constants SHALL live in the shared package pong_pkg.
REQ-027 The loadable down-counter with tick enable and terminal flag SHALL be a sub-module named buzz_timer, instantiated once.

Verification
REQ-028 Pad tone: pad_hit at cycle 10, then 12 game_en pulses -> busy high from cycle 11; buzzer follows pad_buzz_en one cycle late; IDLE and busy=0 on the edge after the 12th tick.
REQ-029 Priority: pad_hit and wall_hit in the same cycle -> state PAD; wall_hit during PAD -> ignored, PAD duration unchanged at 12 ticks.
REQ-030 Retrigger and load precedence: pad_hit coinciding with game_en after 5 ticks of PAD -> counter reloads to 12, no decrement, 12 further ticks before IDLE.
REQ-031 Score jingle: score_hit followed by 96 ticks -> steps 0..5 alternate pad/wall tone every 16 ticks; IDLE after the 96th tick; pad_hit mid-jingle is ignored.
REQ-032 Mute, pause and reset: mute high in PAD -> buzzer 0 while state and counting are unaffected; no game_en for 1000 cycles -> state held; rst mid-WALL -> IDLE, buzzer 0 on the next edge.
